ff_sync_filter: RTL and testbench



---
 rtl/ff_sync_filter.sv | 95 +++++++++
 tb/tb_ff_sync_filter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ff_sync_filter.sv
// Multi-channel CDC synchronizer with per-channel stability filter and
// one-cycle rise/fall/glitch event pulses.

module ff_sync_lane #(
  parameter int   SYNC_REGS     = 3,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RST_BIT       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic glitch
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_REGS-1:0] sync_r;
  logic [CW-1:0]        cnt;
  logic                 s;

  assign s = sync_r[SYNC_REGS-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r <= {SYNC_REGS{RST_BIT}};
      dout   <= RST_BIT;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_REGS-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      if (s == dout) begin
        // Level fell back before acceptance: a pending candidate is dropped.
        cnt    <= '0;
        glitch <= (cnt != '0);
      end else if (cnt == LAST) begin
        dout <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module ff_sync_filter #(
  parameter int                 CHANNELS      = 8,
  parameter int                 SYNC_REGS     = 3,
  parameter int                 FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL    = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] data_i,
  output logic [CHANNELS-1:0] data_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] glitch_o
);
  if (CHANNELS < 1) begin : g_bad_ch
    $error("ff_sync_filter: CHANNELS must be >= 1");
  end
  if (SYNC_REGS < 2) begin : g_bad_sync
    $error("ff_sync_filter: SYNC_REGS must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filt
    $error("ff_sync_filter: FILTER_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ff_sync_lane #(
      .SYNC_REGS    (SYNC_REGS),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_BIT      (RESET_VAL[i])
    ) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .din   (data_i[i]),
      .dout  (data_o[i]),
      .rise  (rise_o[i]),
      .fall  (fall_o[i]),
      .glitch(glitch_o[i])
    );
  end
endmodule

// File: tb/tb_ff_sync_filter.sv
// Scoreboard bench for ff_sync_filter: expected per-cycle outputs are queued
// from the latency rules when stimulus is applied, then popped each edge.

module tb_ff_sync_filter;
  localparam logic [3:0] RV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = RV;
  logic [3:0] dout, rise, fall, glitch;
  logic [3:0] din2 = 4'b0000;
  logic [3:0] dout2, rise2, fall2, glitch2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb[$];
  logic [15:0] expv, got;

  always #5 clk = ~clk;

  ff_sync_filter #(.CHANNELS(4), .SYNC_REGS(3), .FILTER_CYCLES(4), .RESET_VAL(RV)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(din),
    .data_o(dout), .rise_o(rise), .fall_o(fall), .glitch_o(glitch));

  ff_sync_filter #(.CHANNELS(4), .SYNC_REGS(2), .FILTER_CYCLES(1), .RESET_VAL(4'b0000)) dut_fast (
    .clk_i(clk), .rst_i(rst), .data_i(din2),
    .data_o(dout2), .rise_o(rise2), .fall_o(fall2), .glitch_o(glitch2));

  // Leaves the bench #1 after a reset edge with rst released; next edge is edge 1.
  task automatic do_reset();
    din  = RV;
    din2 = 4'b0000;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = RV;
    for (int k = 1; k <= 22; k++) sb.push_back({RV, 4'b0, 4'b0, 4'b0});
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
      expv = sb.pop_front();
      got  = {dout, rise, fall, glitch};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_rise();
    do_reset();
    din = 4'b0111;
    for (int k = 1; k <= 12; k++)
      sb.push_back({(k >= 7) ? 4'b0111 : RV, (k == 7) ? 4'b0010 : 4'b0, 4'b0, 4'b0});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      expv = sb.pop_front();
      got  = {dout, rise, fall, glitch};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL rise k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    din = 4'b1101;
    // s high for three sampled edges (4..6); drop seen at edge 7.
    for (int k = 1; k <= 12; k++)
      sb.push_back({RV, 4'b0, 4'b0, (k == 7) ? 4'b1000 : 4'b0});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 3) din = RV;
      expv = sb.pop_front();
      got  = {dout, rise, fall, glitch};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL glitch k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    din = 4'b0111;
    // Exactly FILTER_CYCLES long: accepted at 7, then returns and falls at 11.
    for (int k = 1; k <= 14; k++)
      sb.push_back({(k >= 7 && k <= 10) ? 4'b0111 : RV,
                    (k == 7) ? 4'b0010 : 4'b0, (k == 11) ? 4'b0010 : 4'b0, 4'b0});
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 4) din = RV;
      expv = sb.pop_front();
      got  = {dout, rise, fall, glitch};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL boundary k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    din = 4'b1010;
    for (int k = 1; k <= 10; k++)
      sb.push_back({(k >= 7) ? 4'b1010 : RV, (k == 7) ? 4'b1010 : 4'b0,
                    (k == 7) ? 4'b0101 : 4'b0, 4'b0});
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      expv = sb.pop_front();
      got  = {dout, rise, fall, glitch};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    do_reset();
    din = 4'b0001;
    // Reset sampled at edge 5; acceptance restarts and lands at edge 12.
    for (int k = 1; k <= 16; k++)
      sb.push_back({(k >= 12) ? 4'b0001 : RV, 4'b0, (k == 12) ? 4'b0100 : 4'b0, 4'b0});
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 4) rst = 1'b1;
      if (k == 5) rst = 1'b0;
      expv = sb.pop_front();
      got  = {dout, rise, fall, glitch};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  task automatic test_fast_build();
    do_reset();
    din2 = 4'b0001;
    for (int k = 1; k <= 6; k++)
      sb.push_back({(k >= 3) ? 4'b0001 : 4'b0, (k == 3) ? 4'b0001 : 4'b0, 4'b0, 4'b0});
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      expv = sb.pop_front();
      got  = {dout2, rise2, fall2, glitch2};
      n_tests++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL fast_build k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_boundary();
    test_simultaneous();
    test_reset_mid_filter();
    test_fast_build();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
